// File: rtl/pipe_stage_reg.sv
// Generic pipeline register with valid/ready flow control, a 2-entry skid buffer,
// flush and bubble insertion. Optional perf counters under `PIPE_REG_PERF_EN.
module pipe_stage_reg #(
  parameter int                 DATA_W      = 141,
  parameter int                 CTRL_W      = 8,
  parameter logic [CTRL_W-1:0]  CTRL_BUBBLE = '0,
  parameter int                 CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_REG_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  if (DATA_W < 1 || CTRL_W < 1 || CNT_W < 1) begin : g_bad_param
    $error("pipe_stage_reg: DATA_W, CTRL_W and CNT_W must be >= 1");
  end

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

  state_e            state_q;
  logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;
  logic [DATA_W-1:0] main_data_q, skid_data_q;

  logic in_fire, out_fire;

  // Handshake flags come only from the state register, so in_ready never
  // depends combinationally on out_ready.
  assign out_valid = (state_q != EMPTY);
  assign in_ready  = (state_q != FULL);
  assign out_ctrl  = out_valid ? main_ctrl_q : CTRL_BUBBLE;
  assign out_data  = main_data_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else if (flush) begin
      state_q <= EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_q     <= ONE;
            main_ctrl_q <= in_ctrl;
            main_data_q <= in_data;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_ctrl_q <= in_ctrl;
            main_data_q <= in_data;
          end else if (in_fire) begin
            state_q     <= FULL;
            skid_ctrl_q <= in_ctrl;
            skid_data_q <= in_data;
          end else if (out_fire) begin
            state_q <= EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_q     <= ONE;
            main_ctrl_q <= skid_ctrl_q;
            main_data_q <= skid_data_q;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

`ifdef PIPE_REG_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Both counters saturate at all-ones rather than wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (out_valid && !out_ready && !flush && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush && (state_q != EMPTY) && !(&flush_cnt_q))
      flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: accepted entries are queued, a negedge
// monitor pops and compares on every downstream transfer.
module tb_pipe_stage_reg;
  localparam int DW = 16;
  localparam int CW = 8;
  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [DW-1:0] in_data, out_data;
`ifdef PIPE_REG_PERF_EN
  logic [NW-1:0] stall_cnt, flush_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [CW+DW-1:0] sb[$];
  logic [CW+DW-1:0] mon_exp;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_BUBBLE(8'h00), .CNT_W(NW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data)
`ifdef PIPE_REG_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Transfer happens at the next posedge when out_valid & out_ready are seen here.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid === 1'b1 && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got %0h expected no output", {out_ctrl, out_data});
        end else begin
          mon_exp = sb.pop_front();
          chk("sb_out", {40'd0, out_ctrl, out_data}, {40'd0, mon_exp});
        end
      end else if (out_valid === 1'b0) begin
        chk("bubble_ctrl", {56'd0, out_ctrl}, 64'h00);
      end
    end
  end

  // One clock: record what the DUT will accept/drop at the coming edge.
  task automatic tick();
    bit r, fl, acc;
    @(negedge clk);
    #1;
    r   = rst;
    fl  = flush;
    acc = in_valid && in_ready && !flush && !rst;
    @(posedge clk);
    if (r) sb.delete();
    else begin
      if (fl) sb.delete();
      if (acc) sb.push_back({in_ctrl, in_data});
    end
    #1;
  endtask

  task automatic send(input logic [CW-1:0] c, input logic [DW-1:0] d);
    in_valid = 1'b1; in_ctrl = c; in_data = d;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 8'hFF; in_data = 16'hABCD;

    // Reset / bubble
    tick(); tick();
    rst = 1'b0; in_valid = 1'b0;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_ctrl", {56'd0, out_ctrl}, 64'h00);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_data", {48'd0, out_data}, 64'h0);

    // Streaming
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_ctrl = 8'h10 + CW'(i); in_data = DW'(i);
      tick();
      chk("stream_in_ready", {63'd0, in_ready}, 64'd1);
      chk("stream_out_valid", {63'd0, out_valid}, 64'd1);
      chk("stream_out_data", {48'd0, out_data}, 64'(i));
    end
    in_valid = 1'b0;
    tick();
    chk("stream_drained", {63'd0, out_valid}, 64'd0);

    // Skid / backpressure; a pending input while FULL must not be taken
    out_ready = 1'b0;
    send(8'hA1, 16'hAAAA);
    chk("skid_in_ready_one", {63'd0, in_ready}, 64'd1);
    send(8'hB2, 16'hBBBB);
    chk("skid_in_ready_full", {63'd0, in_ready}, 64'd0);
    in_valid = 1'b1; in_ctrl = 8'hEE; in_data = 16'hDDDD;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("skid_hold_data", {48'd0, out_data}, 64'hAAAA);
      chk("skid_hold_ctrl", {56'd0, out_ctrl}, 64'hA1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("skid_after_a_data", {48'd0, out_data}, 64'hBBBB);
    chk("skid_after_a_ready", {63'd0, in_ready}, 64'd1);
    tick();
    chk("skid_after_b_valid", {63'd0, out_valid}, 64'd0);

    // Flush while FULL with a new input offered
    out_ready = 1'b0;
    send(8'h31, 16'h3131);
    send(8'h32, 16'h3232);
    chk("flush_pre_full", {63'd0, in_ready}, 64'd0);
    flush = 1'b1; in_valid = 1'b1; in_ctrl = 8'h33; in_data = 16'h3333;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_out_ctrl", {56'd0, out_ctrl}, 64'h00);
    chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
`ifdef PIPE_REG_PERF_EN
    chk("flush_cnt_1", {60'd0, flush_cnt}, 64'd1);
`endif
    out_ready = 1'b1;
    tick(); tick();

    // Flush with a simultaneous downstream transfer: entry still delivered
    out_ready = 1'b0;
    send(8'h41, 16'h4141);
    flush = 1'b1; out_ready = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_fire_out_valid", {63'd0, out_valid}, 64'd0);
`ifdef PIPE_REG_PERF_EN
    chk("flush_cnt_2", {60'd0, flush_cnt}, 64'd2);
`endif

    // Reset has priority over flush
    out_ready = 1'b0;
    send(8'h51, 16'h5151);
    chk("rp_pre_valid", {63'd0, out_valid}, 64'd1);
    rst = 1'b1; flush = 1'b1;
    tick();
    rst = 1'b0; flush = 1'b0;
    chk("rp_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rp_out_data", {48'd0, out_data}, 64'h0);
    chk("rp_in_ready", {63'd0, in_ready}, 64'd1);
`ifdef PIPE_REG_PERF_EN
    chk("rp_flush_cnt", {60'd0, flush_cnt}, 64'd0);
    chk("rp_stall_cnt", {60'd0, stall_cnt}, 64'd0);
`endif

    // Long stall: counter saturates at 15
    send(8'h61, 16'h6161);
    for (int i = 0; i < 20; i++) tick();
    chk("sat_hold_data", {48'd0, out_data}, 64'h6161);
`ifdef PIPE_REG_PERF_EN
    chk("stall_cnt_sat", {60'd0, stall_cnt}, 64'd15);
    tick();
    chk("stall_cnt_sat_hold", {60'd0, stall_cnt}, 64'd15);
`endif
    out_ready = 1'b1;
    tick(); tick();

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
